// File: rtl/period_counter_core.sv
// Measures the clock-cycle interval between successive tick_i pulses and strobes done_o per period.
// Optional feature: define PERIOD_COUNTER_SATURATE_EN to saturate the counter instead of wrapping.
module period_counter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             tick_i,
  output logic [WIDTH-1:0] period_count_o,
  output logic             done_o
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
`ifdef PERIOD_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cnt_inc;

  // cnt_inc is both the next running count and the period reported on a closing tick.
  always_comb begin
`ifdef PERIOD_COUNTER_SATURATE_EN
    cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
`else
    cnt_inc = cnt_q + CNT_ONE;
`endif
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick_i) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (tick_i) begin
          // The closing tick is also the reference for the next period.
          period_d = cnt_inc;
          done_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      done_q   <= done_d;
    end
  end

  assign period_count_o = period_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_period_counter_core.sv
// Scoreboard bench for period_counter_core (WIDTH = 8): a tick-timestamp model predicts each report.
module tb_period_counter_core;

  localparam int unsigned WIDTH = 8;
  localparam longint      MAXV  = (64'd1 << WIDTH) - 1;

  logic             clk;
  logic             rst_n;
  logic             tick;
  logic [WIDTH-1:0] period_count;
  logic             done;

  period_counter_core #(.WIDTH(WIDTH)) dut (
    .clk_i          (clk),
    .reset_ni       (rst_n),
    .tick_i         (tick),
    .period_count_o (period_count),
    .done_o         (done)
  );

  typedef struct {
    longint due;
    longint val;
  } exp_t;

  exp_t   sb_q[$];
  longint cyc      = 0;
  longint held     = 0;
  longint last_tick = 0;
  bit     armed    = 1'b0;
  int     checks   = 0;
  int     failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a period is simply the distance between tick edge indices.
  task automatic model_tick(input longint edge_n);
    longint p;
    exp_t   e;
    if (armed) begin
      p = edge_n - last_tick;
`ifdef PERIOD_COUNTER_SATURATE_EN
      e.val = (p >= MAXV) ? MAXV : p;
`else
      e.val = p % (MAXV + 1);
`endif
      e.due = edge_n;
      sb_q.push_back(e);
    end
    last_tick = edge_n;
    armed     = 1'b1;
  endtask

  task automatic step(input bit t);
    @(posedge clk);
    #1;
    tick = t;
    if (t) model_tick(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick  = 1'b0;
    armed = 1'b0;
    held  = 0;
    sb_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: runs on the falling edge, independent of stimulus.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sb_q.pop_front();
        check("done_cycle", cyc, e.due);
        check("period_value", period_count, e.val);
        held = e.val;
      end
    end else begin
      if (sb_q.size() > 0 && cyc >= sb_q[0].due) begin
        check("missing_done", done, 1);
        void'(sb_q.pop_front());
      end
      check("period_hold", period_count, held);
    end
  end

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // first tick only arms
    step(1'b1);
    idle(10);
    // closing tick (period 11), then periods 5 and 3
    step(1'b1);
    idle(4);
    step(1'b1);
    idle(2);
    step(1'b1);
    idle(6);

    // long period, then hold with no strobes
    step(1'b1);
    idle(250);
    step(1'b1);
    idle(50);

    // consecutive edges and a held-high tick
    step(1'b1);
    step(1'b1);
    idle(3);
    for (int i = 0; i < 4; i++) step(1'b1);
    idle(3);

    // reset mid-measurement discards the partial period
    step(1'b1);
    idle(7);
    do_reset(3);
    idle(2);
    step(1'b1);
    idle(3);
    step(1'b1);
    idle(3);

    // overflow: ticks 300 apart
    step(1'b1);
    idle(299);
    step(1'b1);
    idle(3);

    // randomized periods with occasional resets
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle($urandom_range(1, 5));
        do_reset($urandom_range(1, 4));
      end else begin
        idle($urandom_range(0, 19));
        step(1'b1);
      end
    end
    idle(4);

    check("queue_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
